// File: rtl/handshake_protocol_monitor_if.sv
// Bundle of N valid/ready/data handshake channels observed by the protocol monitor.
// The master modport is the side that drives the bus; the monitor only ever uses slave.
interface handshake_protocol_monitor_if #(
    parameter int N_CH   = 3,
    parameter int DATA_W = 8
);
    logic [N_CH-1:0]        ch_valid;
    logic [N_CH-1:0]        ch_ready;
    logic [N_CH*DATA_W-1:0] ch_data;

    modport master (
        output ch_valid,
        output ch_ready,
        output ch_data
    );

    modport slave (
        input ch_valid,
        input ch_ready,
        input ch_data
    );
endinterface

// File: rtl/handshake_protocol_monitor.sv
// Passive N-channel valid/ready checker: flags valid drops, data changes under stall
// and stall timeouts, captures the first error and keeps saturating transfer counts.
module handshake_protocol_monitor #(
    parameter int N_CH       = 3,
    parameter int DATA_W     = 8,
    parameter int MAX_STALL  = 4,
    parameter int CNT_W      = 8,
    parameter int CHECK_DATA = 1,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    CLK,
    input  logic                    ASYNCRESETN,
    input  logic                    clear,
    handshake_protocol_monitor_if.slave mon,
    output logic [3*N_CH-1:0]       err_sticky,
    output logic                    err_pulse,
    output logic                    first_err_valid,
    output logic [CH_W-1:0]         first_err_chan,
    output logic [1:0]              first_err_code,
    output logic [N_CH*CNT_W-1:0]   xfer_count
);

    localparam int SC_W = $clog2(MAX_STALL + 1);

    typedef logic [SC_W-1:0] stall_t;

    localparam stall_t STALL_SAT  = stall_t'(MAX_STALL);
    localparam stall_t STALL_LAST = stall_t'(MAX_STALL - 1);

    typedef enum logic [1:0] {
        CODE_NONE        = 2'd0,
        CODE_VALID_DROP  = 2'd1,
        CODE_DATA_CHANGE = 2'd2,
        CODE_TIMEOUT     = 2'd3
    } err_code_e;

    logic [N_CH-1:0] det_vd;
    logic [N_CH-1:0] det_dc;
    logic [N_CH-1:0] det_to;
    logic [N_CH-1:0] any_det;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] prev_data_q;
        logic              prev_valid_q;
        logic              prev_ready_q;
        stall_t            stall_cnt_q, stall_cnt_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [2:0]        sticky_q, sticky_d;
        logic              stalled;
        logic              stall_now;
        logic              xfer;

        assign data      = mon.ch_data[g*DATA_W +: DATA_W];
        assign stalled   = prev_valid_q & ~prev_ready_q;
        assign stall_now = mon.ch_valid[g] & ~mon.ch_ready[g];
        assign xfer      = mon.ch_valid[g] & mon.ch_ready[g];

        assign det_vd[g] = stalled & ~mon.ch_valid[g];
        assign det_dc[g] = (CHECK_DATA != 0) && stalled && mon.ch_valid[g] && (data != prev_data_q);
        // Fires only on the LAST->SAT step, so a saturated stall never retriggers.
        assign det_to[g] = stall_now && (stall_cnt_q == STALL_LAST);

        always_comb begin
            stall_cnt_d = '0;
            if (stall_now) begin
                stall_cnt_d = (stall_cnt_q == STALL_SAT) ? stall_cnt_q : stall_cnt_q + 1'b1;
            end

            cnt_d = cnt_q;
            if (clear) begin
                cnt_d = '0;
            end else if (xfer && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end

            sticky_d = clear ? '0 : (sticky_q | {det_to[g], det_dc[g], det_vd[g]});
        end

        // History keeps tracking through clear so a stall spanning it is still timed.
        always_ff @(posedge CLK or negedge ASYNCRESETN) begin
            if (!ASYNCRESETN) begin
                prev_valid_q <= 1'b0;
                prev_ready_q <= 1'b0;
                prev_data_q  <= '0;
                stall_cnt_q  <= '0;
                cnt_q        <= '0;
                sticky_q     <= '0;
            end else begin
                prev_valid_q <= mon.ch_valid[g];
                prev_ready_q <= mon.ch_ready[g];
                prev_data_q  <= data;
                stall_cnt_q  <= stall_cnt_d;
                cnt_q        <= cnt_d;
                sticky_q     <= sticky_d;
            end
        end

        assign err_sticky[3*g +: 3]         = sticky_q;
        assign xfer_count[g*CNT_W +: CNT_W] = cnt_q;
    end

    assign any_det = det_vd | det_dc | det_to;

    logic            pick_found;
    logic [CH_W-1:0] pick_chan;
    err_code_e       pick_code;

    logic            pulse_q, pulse_d;
    logic            fev_q, fev_d;
    logic [CH_W-1:0] fchan_q, fchan_d;
    err_code_e       fcode_q, fcode_d;

    always_comb begin
        pick_found = 1'b0;
        pick_chan  = '0;
        pick_code  = CODE_NONE;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!pick_found && any_det[i]) begin
                pick_found = 1'b1;
                pick_chan  = CH_W'(i);
                if (det_vd[i]) begin
                    pick_code = CODE_VALID_DROP;
                end else if (det_dc[i]) begin
                    pick_code = CODE_DATA_CHANGE;
                end else begin
                    pick_code = CODE_TIMEOUT;
                end
            end
        end
    end

    always_comb begin
        pulse_d = !clear && (|any_det);
        fev_d   = fev_q;
        fchan_d = fchan_q;
        fcode_d = fcode_q;
        if (clear) begin
            fev_d   = 1'b0;
            fchan_d = '0;
            fcode_d = CODE_NONE;
        end else if (!fev_q && pick_found) begin
            fev_d   = 1'b1;
            fchan_d = pick_chan;
            fcode_d = pick_code;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            pulse_q <= 1'b0;
            fev_q   <= 1'b0;
            fchan_q <= '0;
            fcode_q <= CODE_NONE;
        end else begin
            pulse_q <= pulse_d;
            fev_q   <= fev_d;
            fchan_q <= fchan_d;
            fcode_q <= fcode_d;
        end
    end

    assign err_pulse       = pulse_q;
    assign first_err_valid = fev_q;
    assign first_err_chan  = fchan_q;
    assign first_err_code  = fcode_q;

endmodule

// File: doc/handshake_protocol_monitor.md
Name: handshake_protocol_monitor

Overview:
Parametrised, N-channel valid/ready protocol monitor. It is bound alongside an RTL block and generalises the single-channel "valid implies out" property check. It tracks per-channel handshake history and flags protocol violations: valid dropped, data changed under stall, and stall timeout. It keeps sticky error flags, captures the first error, and counts transfers with saturation. It is purely observational and never drives the monitored design.

Parameters:
N_CH, 3, number of monitored handshake channels (1..16)
DATA_W, 8, payload width per channel
MAX_STALL, 4, consecutive stalled cycles that trigger a timeout (>=1)
CNT_W, 8, per-channel transfer counter width
CHECK_DATA, 1, 1 enables the data-stability check; 0 disables it (code 2 never raised)

Ports:
CLK  in  1  clock, rising edge
ASYNCRESETN  in  1  asynchronous active-low reset
clear  in  1  synchronous clear of flags, first-error capture and counters
ch_valid  in  N_CH  per-channel valid
ch_ready  in  N_CH  per-channel ready
ch_data  in  N_CH*DATA_W  payloads; channel i occupies bits [i*DATA_W +: DATA_W]
err_sticky  out  3*N_CH  sticky flags; channel i at [3i+2:3i] = {timeout, data_change, valid_drop}
err_pulse  out  1  high for one cycle when any new violation is registered
first_err_valid  out  1  a first error has been captured
first_err_chan  out  $clog2(N_CH) (min 1)  channel of first error
first_err_code  out  2  1=valid_drop, 2=data_change, 3=timeout
xfer_count  out  N_CH*CNT_W  saturating transfer counts; channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset (ASYNCRESETN=0, asynchronous): all outputs 0. History registers (prev_valid, prev_ready, prev_data, stall_cnt) are 0. No check can fire on the first sample after reset.
- Inputs are sampled on each rising CLK. Violations are detected from the current sample plus the history registers. Flags, pulse and capture are registered at that edge and visible in the following cycle (1-cycle latency).
- Stalled state per channel: prev_valid && !prev_ready.
  - valid_drop: stalled && !valid.
  - data_change: CHECK_DATA && stalled && valid && data != prev_data.
- stall_cnt increments when valid && !ready. It saturates at MAX_STALL and clears to 0 on any sample without valid && !ready.
- timeout is raised once per stall episode, on the sample where stall_cnt transitions MAX_STALL-1 -> MAX_STALL.
- Transfer: valid && ready increments xfer_count[i]. The count holds at 2^CNT_W-1 and does not wrap.
- err_sticky bits set on detection and stay set until clear or reset.
- err_pulse = OR of all detections in that sample, including repeats of an already-sticky flag.
- First-error capture happens only when first_err_valid=0.
  - Multiple channels violating in one sample: lowest channel index wins.
  - Multiple codes on one channel: lowest code wins.
  - Once first_err_valid=1 it is held until clear.
- clear=1 has priority over all same-cycle events:
  - err_sticky, err_pulse, first_err_* and xfer_count go to 0.
  - Detections and transfers in that sample are discarded.
  - History registers still update normally, so a stall spanning clear is still tracked.
- Channels are independent. Simultaneous violations on all channels are each recorded in err_sticky.
- Reset asserted mid-stall clears all history; no error is reported for the interrupted transfer.

Test Plan:
- Ch0 sends valid=1 data=0x5A with ready=1 for 3 cycles -> xfer_count[0]=3, no flags, err_pulse never high.
- Ch1: valid=1, ready=0 for 1 cycle, then valid=0 -> cycle after the drop: err_sticky[3]=1, err_pulse=1 for one cycle, first_err_chan=1, first_err_code=1.
- Ch2: valid=1, ready=0, data 0x11 then 0x22 -> err_sticky[7]=1, code 2. Repeat with CHECK_DATA=0 -> no flag.
- Ch0: valid=1, ready=0 for 6 cycles -> timeout err_sticky[2] sets after the 4th stalled sample, err_pulse only once, no retrigger. Then ready=1 -> count increments, stall_cnt=0.
- Ch1 and ch2 violate in the same cycle -> first_err_chan=1, both sticky bits set. Next cycle clear=1 coincides with a ch0 transfer -> all flags and counts 0, transfer not counted.
- CNT_W=2: 5 transfers on ch0 -> xfer_count[0]=3 (saturated). Assert ASYNCRESETN low mid-stall -> outputs 0 immediately; release with ch0 still valid=0 -> no error.
